// File: rtl/knap_pkg.sv
// Shared types and constants for the knapsack candidate sweep: FSM state type,
// default item count, and the item tables/limits the checker environment uses.
package knap_pkg;

    localparam int N_ITEMS_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } knap_state_t;

    // Items A..K in bit order 0..10
    localparam int ITEM_VAL [N_ITEMS_DEF] = '{12, 7, 9, 3, 15, 5, 8, 11, 4, 6, 10};
    localparam int ITEM_WGT [N_ITEMS_DEF] = '{ 5, 3, 4, 2,  7, 3, 4,  6, 2, 3,  5};
    localparam int ITEM_VOL [N_ITEMS_DEF] = '{ 4, 6, 2, 5,  3, 4, 7,  2, 6, 3,  5};

    localparam int WGT_LIMIT = 20;
    localparam int VOL_LIMIT = 18;
    localparam int VAL_MIN   = 30;

endpackage

// File: rtl/knap_mask_counter.sv
// Candidate mask counter: synchronous clear, count enable, and an all-ones flag
// marking the final mask of the sweep.
module knap_mask_counter #(
    parameter int N_ITEMS = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [N_ITEMS-1:0] count,
    output logic               last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + {{(N_ITEMS-1){1'b0}}, 1'b1};
    end

    assign last = &count;

endmodule

// File: rtl/knap_sweep.sv
// Exhaustive knapsack candidate sweep: steps sel through every mask, counts the
// masks the external checker accepts and records the lowest accepted one.
// Optional macro KNAP_SWEEP_EARLY_STOP_EN stops at the first accepted mask.
module knap_sweep
    import knap_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [N_ITEMS-1:0] sel,
    input  logic               valid_in,
    output logic               busy,
    output logic               done,
    input  logic               ack,
    output logic               found,
    output logic [N_ITEMS-1:0] first_hit,
    output logic [N_ITEMS:0]   hit_count
);

    knap_state_t state_q, state_d;
    logic        cnt_clr, cnt_en, cnt_last;

    knap_mask_counter #(.N_ITEMS(N_ITEMS)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (sel),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_clr = 1'b1;
                end
            end
            ST_RUN: begin
`ifdef KNAP_SWEEP_EARLY_STOP_EN
                // sel freezes on the first accepted mask
                if (valid_in || cnt_last)
                    state_d = ST_DONE;
                else
                    cnt_en = 1'b1;
`else
                if (cnt_last)
                    state_d = ST_DONE;
                else
                    cnt_en = 1'b1;
`endif
            end
            ST_DONE: begin
                if (ack)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Results persist through DONE and IDLE; only a new start clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found     <= 1'b0;
            first_hit <= '0;
            hit_count <= '0;
        end else if (state_q == ST_IDLE && start) begin
            found     <= 1'b0;
            first_hit <= '0;
            hit_count <= '0;
        end else if (state_q == ST_RUN && valid_in) begin
            hit_count <= hit_count + {{N_ITEMS{1'b0}}, 1'b1};
            if (!found) begin
                found     <= 1'b1;
                first_hit <= sel;
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_knap_sweep.sv
// Randomized self-checking bench for knap_sweep against an enumeration model.
module tb_knap_sweep;
    import knap_pkg::*;

    localparam int N    = N_ITEMS_DEF;
    localparam int NMSK = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         ack = 1'b0;
    logic         valid_in;
    logic [N-1:0] sel;
    logic         busy, done, found;
    logic [N-1:0] first_hit;
    logic [N:0]   hit_count;

    int mode = 0;
    int rnd_a = 0;
    int rnd_m = 1;
    int thr = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    knap_sweep #(.N_ITEMS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel       (sel),
        .valid_in  (valid_in),
        .busy      (busy),
        .done      (done),
        .ack       (ack),
        .found     (found),
        .first_hit (first_hit),
        .hit_count (hit_count)
    );

    function automatic bit knap_ok(input int m);
        int v, w, u;
        v = 0; w = 0; u = 0;
        for (int i = 0; i < N; i++)
            if (m[i]) begin
                v += ITEM_VAL[i];
                w += ITEM_WGT[i];
                u += ITEM_VOL[i];
            end
        return (w <= WGT_LIMIT) && (u <= VOL_LIMIT) && (v >= VAL_MIN);
    endfunction

    function automatic bit valid_fn(input int md, input int m);
        case (md)
            0: return 1'b0;
            1: return (m == 'h123) || (m == 'h400);
            2: return 1'b1;
            3: return knap_ok(m);
            4: return ((m ^ rnd_a) % rnd_m) == 0;
            5: return m >= thr;
            default: return 1'b0;
        endcase
    endfunction

    always_comb valid_in = valid_fn(mode, int'(sel));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Enumerate every mask in order to get what one sweep should report
    task automatic model(input int md, output int ef, output int efirst, output int ecnt,
                         output int ecyc, output int esel);
        ef = 0; efirst = 0; ecnt = 0;
        for (int m = 0; m < NMSK; m++)
            if (valid_fn(md, m)) begin
                if (ef == 0) begin
                    ef = 1;
                    efirst = m;
                end
                ecnt++;
            end
        ecyc = NMSK;
        esel = NMSK - 1;
`ifdef KNAP_SWEEP_EARLY_STOP_EN
        if (ef != 0) begin
            ecnt = 1;
            ecyc = efirst + 1;
            esel = efirst;
        end
`endif
    endtask

    task automatic run_sweep(input int md, input string tag, input bit go_now);
        int ef, efirst, ecnt, ecyc, esel, cyc, both;
        model(md, ef, efirst, ecnt, ecyc, esel);
        mode = md;
        ack = 1'b0;
        if (!go_now) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        cyc = 0;
        both = 0;
        while (busy && cyc < 5000) begin
            if (done) both++;
            // stray start/ack while running must have no effect
            ack   = ($urandom_range(0, 7) == 0);
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            cyc++;
        end
        ack = 1'b0;
        start = 1'b0;
        chk({tag, ".run_cycles"}, 32'(cyc), 32'(ecyc));
        chk({tag, ".busy_done_overlap"}, 32'(both), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".found"}, 32'(found), 32'(ef));
        chk({tag, ".first_hit"}, 32'(first_hit), 32'(efirst));
        chk({tag, ".hit_count"}, 32'(hit_count), 32'(ecnt));
        chk({tag, ".sel"}, 32'(sel), 32'(esel));
        start = 1'b1;
        @(negedge clk);
        chk({tag, ".done_hold"}, 32'({done, busy}), 32'b10);
        chk({tag, ".count_hold"}, 32'(hit_count), 32'(ecnt));
        ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack = 1'b0;
        chk({tag, ".ack_idle"}, 32'({done, busy}), 32'b00);
        @(negedge clk);
        chk({tag, ".idle_keep"}, 32'({found, first_hit, hit_count}),
            32'({ef[0], efirst[N-1:0], ecnt[N:0]}));
    endtask

    initial begin
        int cyc;
        #2;
        chk("rst.state", 32'({busy, done, found}), 32'd0);
        chk("rst.sel", 32'(sel), 32'd0);
        chk("rst.results", 32'({first_hit, hit_count}), 32'd0);
        // release reset and start on the very first edge
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        run_sweep(0, "zero", 1'b1);
        run_sweep(1, "two_hits", 1'b0);
        run_sweep(2, "all_ones", 1'b0);
        thr = 'hA0;
        run_sweep(5, "thr_a0", 1'b0);
        run_sweep(3, "knap", 1'b0);
        for (int k = 0; k < 4; k++) begin
            rnd_a = $urandom_range(0, NMSK - 1);
            rnd_m = $urandom_range(3, 300);
            run_sweep(4, "rnd_mod", 1'b0);
            thr = $urandom_range(0, NMSK + 10);
            run_sweep(5, "rnd_thr", 1'b0);
        end

        // Abandon a sweep mid-run with an asynchronous reset
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid.reached", 32'(cyc), 32'd500);
        #2 rst = 1'b1;
        #1;
        chk("mid.state", 32'({busy, done, found}), 32'd0);
        chk("mid.sel", 32'(sel), 32'd0);
        chk("mid.results", 32'({first_hit, hit_count}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mid.held", 32'({busy, done, found, sel, hit_count}), 32'd0);
        rst = 1'b0;
        start = 1'b1;
        run_sweep(1, "after_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
